pong_game_ctrl: RTL

Game-flow controller that sits directly downstream of the pong graphics block's `miss` output and upstream of its `graph_still` input. It sequences a two-player match through new-game, serve, play and game-over phases, and keeps both players' scores in BCD. It paces serve delays from the frame-refresh tick, which it derives from the pixel counters. It also drives a status selector for the text/overlay stage.

---
 rtl/pong_game_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences new-game / play / serve / game-over phases,
// keeps both players' BCD scores and paces the serve delay from the frame refresh tick.
module pong_game_ctrl #(
  parameter int unsigned SERVE_FRAMES = 120,
  parameter logic [7:0]  WIN_SCORE    = 8'h11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       start_btn,
  input  logic       miss,
  input  logic       miss_side,
  output logic       graph_still,
  output logic [7:0] score_l,
  output logic [7:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] text_sel
);

  typedef enum logic [1:0] {StNewGame, StPlay, StServe, StOver} state_e;

  localparam logic [7:0] ServeLoad = 8'(SERVE_FRAMES);

  state_e     state_q, state_d;
  logic       btn_q;
  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic [7:0] score_l_q, score_l_d;
  logic [7:0] score_r_q, score_r_d;
  logic       winner_q, winner_d;

  logic       refr_tick;
  logic       btn_rise;
  logic [7:0] inc_l, inc_r, new_score;

  // Two-digit BCD increment that saturates at 99 instead of wrapping.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign refr_tick = (pix_y == 10'd481) && (pix_x == 10'd0);
  assign btn_rise  = start_btn & ~btn_q;
  assign inc_l     = bcd_inc(score_l_q);
  assign inc_r     = bcd_inc(score_r_q);
  // miss_side names the player who missed; the other one scores.
  assign new_score = miss_side ? inc_l : inc_r;

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    unique case (state_q)
      StNewGame: begin
        if (btn_rise) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        // A miss outranks a simultaneous button press.
        if (miss) begin
          if (miss_side) begin
            score_l_d = inc_l;
          end else begin
            score_r_d = inc_r;
          end
          if (new_score == WIN_SCORE) begin
            state_d  = StOver;
            winner_d = ~miss_side;
          end else begin
            serve_cnt_d = ServeLoad;
            state_d     = StServe;
          end
        end
      end
      StServe: begin
        if (refr_tick && (serve_cnt_q != 8'd0)) begin
          serve_cnt_d = serve_cnt_q - 8'd1;
        end
        if (btn_rise || (refr_tick && (serve_cnt_q == 8'd1))) begin
          state_d = StPlay;
        end
      end
      StOver: begin
        if (btn_rise) begin
          state_d   = StNewGame;
          score_l_d = 8'h00;
          score_r_d = 8'h00;
          winner_d  = 1'b0;
        end
      end
      default: state_d = StNewGame;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StNewGame;
      btn_q       <= 1'b0;
      serve_cnt_q <= 8'd0;
      score_l_q   <= 8'h00;
      score_r_q   <= 8'h00;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= start_btn;
      serve_cnt_q <= serve_cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    graph_still = 1'b1;
    game_over   = 1'b0;
    text_sel    = 2'b00;
    unique case (state_q)
      StNewGame: text_sel = 2'b00;
      StPlay: begin
        graph_still = 1'b0;
        text_sel    = 2'b01;
      end
      StServe:   text_sel = 2'b10;
      StOver: begin
        game_over = 1'b1;
        text_sel  = 2'b11;
      end
      default: text_sel = 2'b00;
    endcase
  end

  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign winner  = winner_q;

endmodule
